// File: rtl/ifu_pcgen.sv
// ============================================================================
// ifu_pcgen: fetch-PC generator feeding predictor, imem and decode
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef BP_ADDR_BITS
`define BP_ADDR_BITS 32
`endif
`ifndef BP_ADDR_DEPTH
`define BP_ADDR_DEPTH 16
`endif

module ifu_pcgen #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BP_PC_BITS = `BP_ADDR_BITS,
    parameter int          BP_ADDR_W  = $clog2(`BP_ADDR_DEPTH),
    parameter int          DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  bp_req_valid,
    input  logic                  bp_req_ready,
    output logic [BP_PC_BITS-1:0] bp_req_pc,
    input  logic                  bp_resp_valid,
    input  logic                  bp_resp_match,
    input  logic [BP_ADDR_W-1:0]  bp_resp_addr,
    input  logic [31:0]           bp_resp_pc,
    output logic                  ifetch_req_valid,
    input  logic                  ifetch_req_ready,
    output logic [31:0]           ifetch_req_addr,
    input  logic                  ifetch_resp_valid,
    input  logic [31:0]           ifetch_resp_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst_data,
    output logic [31:0]           inst_pc,
    output logic                  inst_bp_taken,
    output logic                  inst_bp_match,
    output logic [BP_ADDR_W-1:0]  inst_bp_addr
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_pc;
    logic [31:0]          r_q_pc    [DEPTH];
    logic [31:0]          r_q_data  [DEPTH];
    logic                 r_q_taken [DEPTH];
    logic                 r_q_match [DEPTH];
    logic [BP_ADDR_W-1:0] r_q_addr  [DEPTH];
    logic [DEPTH-1:0]     r_q_has_data;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_fill_ptr;
    logic [CNT_W-1:0]     r_fifo_cnt;
    logic [CNT_W-1:0]     r_inflight;
    logic [CNT_W-1:0]     r_drop_cnt;

    logic                 w_can_issue;
    logic                 w_fire;
    logic                 w_resp_take;
    logic                 w_resp_fill;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_inflight_nxt;
    logic [CNT_W-1:0]     w_drop_nxt;

    // Issue decisions use registered counts only, so a pop never frees credit in the same cycle.
    assign w_can_issue = (r_state != ST_BOOT) && !redirect_valid &&
                         (r_fifo_cnt < C_DEPTH) && (r_inflight < C_DEPTH);
    assign w_fire      = w_can_issue && bp_req_ready && ifetch_req_ready;
    assign w_resp_take = ifetch_resp_valid && (r_inflight != '0);
    assign w_resp_fill = w_resp_take && !redirect_valid && (r_drop_cnt == '0);
    assign w_pop       = r_q_has_data[r_rd_ptr] && inst_ready;

    assign w_inflight_nxt = r_inflight + CNT_W'(w_fire) - CNT_W'(w_resp_take);

    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_nxt = w_inflight_nxt;
        end else if (w_resp_take && (r_drop_cnt != '0)) begin
            w_drop_nxt = r_drop_cnt - 1'b1;
        end
    end

    assign bp_req_valid     = w_can_issue;
    assign bp_req_pc        = r_pc[BP_PC_BITS-1:0];
    assign ifetch_req_valid = w_can_issue && bp_req_ready;
    assign ifetch_req_addr  = r_pc;

    assign inst_valid    = r_q_has_data[r_rd_ptr];
    assign inst_data     = r_q_data[r_rd_ptr];
    assign inst_pc       = r_q_pc[r_rd_ptr];
    assign inst_bp_taken = r_q_taken[r_rd_ptr];
    assign inst_bp_match = r_q_match[r_rd_ptr];
    assign inst_bp_addr  = r_q_addr[r_rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_q_has_data <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_fill_ptr   <= '0;
            r_fifo_cnt   <= '0;
            r_inflight   <= '0;
            r_drop_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_data[i]  <= '0;
                r_q_taken[i] <= 1'b0;
                r_q_match[i] <= 1'b0;
                r_q_addr[i]  <= '0;
            end
        end else begin
            r_inflight <= w_inflight_nxt;
            r_drop_cnt <= w_drop_nxt;

            case (r_state)
                ST_BOOT:  r_state <= ST_RUN;
                ST_RUN:   if (w_drop_nxt != '0) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_drop_nxt == '0) r_state <= ST_RUN;
                default:  r_state <= ST_BOOT;
            endcase

            if (redirect_valid) begin
                r_pc         <= redirect_pc;
                r_q_has_data <= '0;
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
                r_fill_ptr   <= '0;
                r_fifo_cnt   <= '0;
            end else begin
                if (w_fire) begin
                    r_pc               <= bp_resp_valid ? bp_resp_pc : r_pc + 32'd4;
                    r_q_pc[r_wr_ptr]    <= r_pc;
                    r_q_taken[r_wr_ptr] <= bp_resp_valid;
                    r_q_match[r_wr_ptr] <= bp_resp_match;
                    r_q_addr[r_wr_ptr]  <= bp_resp_addr;
                    r_wr_ptr            <= r_wr_ptr + 1'b1;
                end
                // Responses return in order, so the fill pointer trails the write pointer.
                if (w_resp_fill) begin
                    r_q_data[r_fill_ptr]     <= ifetch_resp_data;
                    r_q_has_data[r_fill_ptr] <= 1'b1;
                    r_fill_ptr               <= r_fill_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_q_has_data[r_rd_ptr] <= 1'b0;
                    r_rd_ptr               <= r_rd_ptr + 1'b1;
                end
                r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_fire) - CNT_W'(w_pop);
            end
        end
    end

    // A response with nothing outstanding has no entry to land in and is ignored.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rstn)
        !(ifetch_resp_valid && (r_inflight == '0)));

endmodule

`default_nettype wire
